// File: rtl/fpmul_arbiter.sv
// Round-robin sharing of one pipelined FP multiplier between two requesters.
// A tag pipeline matched to the multiplier latency steers each product back to its issuer.
module fpmul_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HOLD,
  input  logic              REQ0_VALID,
  input  logic [DATA_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ0_B,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [DATA_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ1_B,
  output logic              REQ1_READY,
  output logic [DATA_W-1:0] MUL_A,
  output logic [DATA_W-1:0] MUL_B,
  input  logic [DATA_W-1:0] MUL_Z,
  output logic              RES0_VALID,
  output logic [DATA_W-1:0] RES0_Z,
  output logic              RES1_VALID,
  output logic [DATA_W-1:0] RES1_Z,
  output logic              BUSY
);
  // One extra stage beyond the multiplier latency: the final stage lines up with
  // the cycle in which MUL_Z is valid, and the result register samples it.
  localparam int DEPTH = MUL_LAT + 1;

  logic              gnt0, gnt1, issue;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [DEPTH-1:0]  tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic              res0_vld_q, res0_vld_d, res1_vld_q, res1_vld_d;
  logic [DATA_W-1:0] res0_z_q, res0_z_d, res1_z_q, res1_z_d;
  logic              busy_q, busy_d;

  // Tie goes to the requester that was not granted last.
  always_comb begin : arbitrate
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST && !HOLD) begin
      if (REQ0_VALID && REQ1_VALID) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = REQ0_VALID;
        gnt1 = REQ1_VALID;
      end
    end
  end

  assign issue = gnt0 | gnt1;

  always_comb begin : next_state
    last_grant_d = last_grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
      mul_a_d      = REQ0_A;
      mul_b_d      = REQ0_B;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      mul_a_d      = REQ1_A;
      mul_b_d      = REQ1_B;
    end

    tag_vld_d = {tag_vld_q[DEPTH-2:0], issue};
    tag_id_d  = {tag_id_q[DEPTH-2:0], gnt1};
    busy_d    = |tag_vld_d;

    res0_vld_d = tag_vld_q[DEPTH-1] & ~tag_id_q[DEPTH-1];
    res1_vld_d = tag_vld_q[DEPTH-1] &  tag_id_q[DEPTH-1];
    res0_z_d   = res0_vld_d ? MUL_Z : res0_z_q;
    res1_z_d   = res1_vld_d ? MUL_Z : res1_z_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      res0_vld_q   <= 1'b0;
      res1_vld_q   <= 1'b0;
      res0_z_q     <= '0;
      res1_z_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      res0_vld_q   <= res0_vld_d;
      res1_vld_q   <= res1_vld_d;
      res0_z_q     <= res0_z_d;
      res1_z_q     <= res1_z_d;
      busy_q       <= busy_d;
    end
  end

  assign REQ0_READY = gnt0;
  assign REQ1_READY = gnt1;
  assign MUL_A      = mul_a_q;
  assign MUL_B      = mul_b_q;
  assign RES0_VALID = res0_vld_q;
  assign RES0_Z     = res0_z_q;
  assign RES1_VALID = res1_vld_q;
  assign RES1_Z     = res1_z_q;
  assign BUSY       = busy_q;
endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
- Shares one pipelined single-precision multiplier instance (FPmul) between two requesters.
- Accepts operand pairs over valid/ready handshakes and arbitrates round-robin, issuing at most one operation per cycle.
- Carries a requester tag alongside each operation through a shift register matched to the multiplier latency, then steers each product back to the requester that issued it.
- Sits between the requesters and the FPmul ports FP_A, FP_B and FP_Z.

Parameters:
- DATA_W, 32: operand/result width (IEEE-754 single).
- MUL_LAT, 4: edges from FP_A/FP_B change to the corresponding FP_Z being valid. Must be >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- HOLD  in  1  when high, no new grants; in-flight operations still complete.
- REQ0_VALID  in  1  requester 0 has an operand pair.
- REQ0_A  in  DATA_W  requester 0 operand A.
- REQ0_B  in  DATA_W  requester 0 operand B.
- REQ0_READY  out  1  requester 0 granted this cycle (combinational).
- REQ1_VALID  in  1  requester 1 has an operand pair.
- REQ1_A  in  DATA_W  requester 1 operand A.
- REQ1_B  in  DATA_W  requester 1 operand B.
- REQ1_READY  out  1  requester 1 granted this cycle (combinational).
- MUL_A  out  DATA_W  to FPmul FP_A; registered.
- MUL_B  out  DATA_W  to FPmul FP_B; registered.
- MUL_Z  in  DATA_W  from FPmul FP_Z.
- RES0_VALID  out  1  one-cycle pulse: RES0_Z holds requester 0's product.
- RES0_Z  out  DATA_W  requester 0 product.
- RES1_VALID  out  1  one-cycle pulse: RES1_Z holds requester 1's product.
- RES1_Z  out  DATA_W  requester 1 product.
- BUSY  out  1  at least one operation in flight or pending output.

Behaviour:
- Reset:
  - Sampled at a rising CLK edge with RST=1.
  - All outputs are 0: MUL_A, MUL_B, RESn_Z, RESn_VALID, BUSY.
  - Tag pipeline is cleared.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - While RST=1, both READYs are 0.
- Arbitration (combinational, each cycle):
  - If HOLD=1 or RST=1, both READYs are 0.
  - Else if exactly one REQn_VALID is high, that READY is 1.
  - Else if both are high, the requester != last_grant gets READY.
  - At most one READY is high in any cycle.
- Issue at an edge where REQn_VALID & REQn_READY:
  - MUL_A/MUL_B <= REQn_A/REQn_B.
  - last_grant <= n.
  - Tag {valid=1, id=n} enters stage 0 of the tag shift register.
- No issue:
  - MUL_A/MUL_B hold their previous value.
  - Tag {valid=0} enters.
- Tag pipeline:
  - Depth is MUL_LAT+1; it shifts every cycle regardless of HOLD.
  - When the final stage is valid, RES<id>_Z <= MUL_Z and RES<id>_VALID <= 1 at that edge. The other requester's VALID is 0 and its Z holds.
- Latency:
  - Handshake edge e0, result edge e0+MUL_LAT+1.
  - RESn_VALID is high for exactly the cycle following that edge.
- Ordering and throughput:
  - Results return in issue order.
  - Back-to-back issues produce back-to-back result pulses.
  - Sustained throughput is 1 op/cycle total. With both requesters continuously valid, each gets 1 op per 2 cycles.
- No result back-pressure: requesters must accept RESn_VALID when it pulses.
- BUSY = OR of all tag valid bits (registered with the tags).
- HOLD asserted mid-stream:
  - No issue that cycle.
  - Pending REQ_VALID stays pending; requesters must hold their operands stable.
  - Already-issued results still return.
  - Deasserting HOLD resumes arbitration from the saved last_grant.
- Reset mid-operation: all in-flight tags are dropped, no RES pulses are produced for them, and outputs return to reset values on the reset edge.
- Simultaneous events: an issue and a result on the same edge are independent and both occur.

Test Plan:
1. Single requester: REQ0 sends 0x3FC00000*0x40000000 (1.5*2.0).
   - RES0_VALID pulses exactly MUL_LAT+1 edges after the handshake with RES0_Z=0x40400000.
   - RES1_VALID stays 0.
2. Contention: both valid for 4 cycles after reset.
   - Grants go 0,1,0,1.
   - RES pulses alternate 0,1,0,1 with correct products, e.g. REQ1 2.0*2.0 -> 0x40800000.
3. Streaming: REQ0 valid 8 consecutive cycles alone.
   - 8 grants back-to-back; 8 consecutive RES0_VALID pulses in order.
   - BUSY high throughout, low MUL_LAT+1 cycles after the last issue.
4. HOLD: raise HOLD for 3 cycles while both are valid and 2 ops are in flight.
   - READYs are 0 during HOLD and the 2 results still return.
   - After HOLD drops, the grant goes to the requester != last_grant.
5. Reset mid-flight: issue 3 ops, assert RST for 1 cycle 2 edges later.
   - No RES pulses follow, BUSY=0, MUL_A=MUL_B=0.
   - The next tie grants requester 0.
6. Parameter sweep: repeat scenarios 1 and 3 with MUL_LAT=1 and MUL_LAT=6, using an FPmul model of matching depth.
   - Latency equals MUL_LAT+1 in each case.
